// File: rtl/ehl_ahb_matrix_in_pkg.sv
// Shared AHB encodings and FSM state codes for the matrix input stage.
// Also holds the registered address-phase record that the stage replays to the slaves.
package ehl_ahb_matrix_in_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [3:0]  hprot;
    } areg_t;

    function automatic logic trans_valid(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ehl_ahb_decoder.sv
// Combinational address map lookup: one-hot hit vector plus the winning slave index.
// A miss on every slave returns SNUM, which selects the internal default slave.
module ehl_ahb_decoder #(
    parameter int                 SNUM      = 4,
    parameter logic [SNUM*32-1:0] ADDR_BASE = {SNUM{32'h0}},
    parameter logic [SNUM*32-1:0] ADDR_MASK = {SNUM{32'h0}},
    parameter int                 SELW      = $clog2(SNUM + 1)
) (
    input  logic [31:0]     haddr_i,
    output logic [SNUM-1:0] hit_o,
    output logic [SELW-1:0] sel_o
);

    generate
        for (genvar gi = 0; gi < SNUM; gi++) begin : g_hit
            assign hit_o[gi] = (haddr_i & ADDR_MASK[gi*32 +: 32]) == ADDR_BASE[gi*32 +: 32];
        end
    endgenerate

    // Walk from the top so the lowest hitting index is the last one written.
    always_comb begin
        sel_o = SELW'(SNUM);
        for (int s = SNUM - 1; s >= 0; s--) begin
            if (hit_o[s]) begin
                sel_o = SELW'(s);
            end
        end
    end

endmodule

// File: rtl/ehl_ahb_matrix_in.sv
// AHB matrix input stage for one master port: registers the address phase, decodes it,
// issues it to one slave port and routes that slave's response back; misses get a two-cycle ERROR.
module ehl_ahb_matrix_in
    import ehl_ahb_matrix_in_pkg::*;
#(
    parameter int                 SNUM      = 4,
    parameter logic [SNUM*32-1:0] ADDR_BASE = {SNUM{32'h0}},
    parameter logic [SNUM*32-1:0] ADDR_MASK = {SNUM{32'h0}}
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [31:0]        m_haddr,
    input  logic [1:0]         m_htrans,
    input  logic               m_hwrite,
    input  logic [2:0]         m_hsize,
    input  logic [2:0]         m_hburst,
    input  logic [3:0]         m_hprot,
    input  logic [31:0]        m_hwdata,
    output logic [31:0]        m_hrdata,
    output logic               m_hready,
    output logic [1:0]         m_hresp,
    output logic [31:0]        s_haddr,
    output logic [SNUM*2-1:0]  s_htrans,
    output logic               s_hwrite,
    output logic [2:0]         s_hsize,
    output logic [2:0]         s_hburst,
    output logic [3:0]         s_hprot,
    output logic [31:0]        s_hwdata,
    input  logic [SNUM-1:0]    s_hready,
    input  logic [SNUM*2-1:0]  s_hresp,
    input  logic [SNUM*32-1:0] s_hrdata
);

    localparam int SELW = $clog2(SNUM + 1);

    logic [2:0]      state_q, state_d;
    areg_t           areg_q, areg_d;
    logic [SELW-1:0] sel_q, sel_d;

    logic [SNUM-1:0] dec_hit;
    logic [SELW-1:0] dec_sel;
    logic            capture;
    logic            sel_hready;

    // Slave response vectors extended with a benign entry at index SNUM (the default slave).
    logic [SNUM:0]   hready_x;
    logic [1:0]      hresp_x  [SNUM+1];
    logic [31:0]     hrdata_x [SNUM+1];

    ehl_ahb_decoder #(
        .SNUM      (SNUM),
        .ADDR_BASE (ADDR_BASE),
        .ADDR_MASK (ADDR_MASK),
        .SELW      (SELW)
    ) u_decoder (
        .haddr_i (m_haddr),
        .hit_o   (dec_hit),
        .sel_o   (dec_sel)
    );

    generate
        for (genvar gi = 0; gi < SNUM; gi++) begin : g_slave
            assign hready_x[gi] = s_hready[gi];
            assign hresp_x[gi]  = s_hresp[gi*2 +: 2];
            assign hrdata_x[gi] = s_hrdata[gi*32 +: 32];
            assign s_htrans[gi*2 +: 2] = (state_q == ST_ADDR && sel_q == SELW'(gi)) ?
                                         areg_q.htrans : HTRANS_IDLE;
        end
    endgenerate

    assign hready_x[SNUM] = 1'b1;
    assign hresp_x[SNUM]  = HRESP_OKAY;
    assign hrdata_x[SNUM] = 32'h0;

    assign sel_hready = hready_x[sel_q];

    assign s_haddr  = areg_q.haddr;
    assign s_hwrite = areg_q.hwrite;
    assign s_hsize  = areg_q.hsize;
    assign s_hburst = areg_q.hburst;
    assign s_hprot  = areg_q.hprot;
    assign s_hwdata = m_hwdata;

    always_comb begin
        m_hready = 1'b1;
        m_hresp  = HRESP_OKAY;
        m_hrdata = 32'h0;
        case (state_q)
            ST_ADDR: m_hready = 1'b0;
            ST_DATA: begin
                m_hready = sel_hready;
                m_hresp  = hresp_x[sel_q];
                m_hrdata = hrdata_x[sel_q];
            end
            ST_ERR1: begin
                m_hready = 1'b0;
                m_hresp  = HRESP_ERROR;
            end
            ST_ERR2: m_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // A new address phase is taken whenever the master sees hready high, whatever the state.
    assign capture = m_hready && trans_valid(m_htrans);

    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_ADDR: if (sel_hready) state_d = ST_DATA;
            ST_DATA: if (sel_hready) state_d = ST_IDLE;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            areg_d.haddr  = m_haddr;
            areg_d.htrans = m_htrans;
            areg_d.hwrite = m_hwrite;
            areg_d.hsize  = m_hsize;
            areg_d.hburst = m_hburst;
            areg_d.hprot  = m_hprot;
            sel_d         = dec_sel;
            state_d       = (|dec_hit) ? ST_ADDR : ST_ERR1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            areg_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_ehl_ahb_matrix_in.sv
// Self-checking bench for ehl_ahb_matrix_in with two slaves (0x0xxx_xxxx and 0x1xxx_xxxx).
// Expected responses are queued when a transfer is issued and popped when the master sees hready.
module tb_ehl_ahb_matrix_in;
    import ehl_ahb_matrix_in_pkg::*;

    localparam int          SNUM = 2;
    localparam logic [63:0] BASE = {32'h1000_0000, 32'h0000_0000};
    localparam logic [63:0] MASK = {32'hF000_0000, 32'hF000_0000};
    localparam logic [31:0] RD0  = 32'h1111_2222;
    localparam logic [31:0] RD1  = 32'hCAFE_F00D;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [2:0]  m_hburst;
    logic [3:0]  m_hprot;
    logic [31:0] m_hwdata;
    logic [31:0] m_hrdata;
    logic        m_hready;
    logic [1:0]  m_hresp;
    logic [31:0] s_haddr;
    logic [3:0]  s_htrans;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic [3:0]  s_hprot;
    logic [31:0] s_hwdata;
    logic [1:0]  s_hready;
    logic [3:0]  s_hresp;
    logic [63:0] s_hrdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 hclk = ~hclk;

    ehl_ahb_matrix_in #(
        .SNUM      (SNUM),
        .ADDR_BASE (BASE),
        .ADDR_MASK (MASK)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .m_haddr  (m_haddr),
        .m_htrans (m_htrans),
        .m_hwrite (m_hwrite),
        .m_hsize  (m_hsize),
        .m_hburst (m_hburst),
        .m_hprot  (m_hprot),
        .m_hwdata (m_hwdata),
        .m_hrdata (m_hrdata),
        .m_hready (m_hready),
        .m_hresp  (m_hresp),
        .s_haddr  (s_haddr),
        .s_htrans (s_htrans),
        .s_hwrite (s_hwrite),
        .s_hsize  (s_hsize),
        .s_hburst (s_hburst),
        .s_hprot  (s_hprot),
        .s_hwdata (s_hwdata),
        .s_hready (s_hready),
        .s_hresp  (s_hresp),
        .s_hrdata (s_hrdata)
    );

    // Issues one transfer from an idle bus and follows it to completion, acting as the slave
    // (optional data-phase stalls and ERROR). Returns what was observed; callers do the checks.
    task automatic do_xfer(input logic [31:0] addr, input logic [1:0] trans, input logic wr,
                           input logic [31:0] wdata, input int sl, input int stall, input logic serr,
                           output int lowcnt, output int addrcyc, output int errcyc,
                           output logic [3:0] trans_or, output logic wd_bad, output logic hw_addr,
                           output logic [31:0] rdata, output logic [1:0] resp, output logic to);
        int   left;
        logic in_data;
        logic saw_addr;
        m_haddr  = addr;
        m_htrans = trans;
        m_hwrite = wr;
        @(posedge hclk); #1;
        m_htrans = HTRANS_IDLE;
        m_hwdata = wdata;
        lowcnt = 0; addrcyc = 0; errcyc = 0; trans_or = '0; wd_bad = 1'b0; hw_addr = 1'b0;
        rdata = '0; resp = '0; to = 1'b1; left = stall; in_data = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge hclk);
            trans_or = trans_or | s_htrans;
            saw_addr = (s_htrans != 4'b0);
            if (saw_addr) begin
                addrcyc++;
                hw_addr = s_hwrite;
            end
            if (m_hresp == HRESP_ERROR) errcyc++;
            if (s_hwdata !== wdata) wd_bad = 1'b1;
            if (m_hready === 1'b1) begin
                rdata = m_hrdata;
                resp  = m_hresp;
                to    = 1'b0;
                break;
            end
            lowcnt++;
            @(posedge hclk); #1;
            if (saw_addr) begin
                in_data = 1'b1;
                if (stall > 0) s_hready[sl] = 1'b0;
                if (serr) s_hresp[sl*2 +: 2] = HRESP_ERROR;
            end else if (in_data && left > 0) begin
                left--;
                if (left == 0) s_hready[sl] = 1'b1;
            end
        end
        @(posedge hclk); #1;
        s_hready = 2'b11;
        s_hresp  = 4'b0000;
        $display("xfer addr=%h trans=%0d wr=%0d waits=%0d resp=%0d rdata=%h", addr, trans, wr,
                 lowcnt, resp, rdata);
    endtask

    task automatic test_reset();
        hresetn  = 1'b0;
        m_haddr  = 32'h1000_0000;
        m_htrans = HTRANS_NONSEQ;
        m_hwrite = 1'b0;
        m_hsize  = 3'b010;
        m_hburst = 3'b001;
        m_hprot  = 4'b0011;
        m_hwdata = 32'h0;
        s_hready = 2'b11;
        s_hresp  = 4'b0000;
        s_hrdata = {RD1, RD0};
        repeat (3) @(negedge hclk);
        checks++; if (m_hready !== 1'b1) begin errors++; $display("FAIL rst_hready: got %b expected 1", m_hready); end
        checks++; if (m_hresp !== HRESP_OKAY) begin errors++; $display("FAIL rst_hresp: got %b expected 00", m_hresp); end
        checks++; if (m_hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h expected 0", m_hrdata); end
        checks++; if (s_htrans !== 4'b0) begin errors++; $display("FAIL rst_htrans: got %b expected 0000", s_htrans); end
        checks++; if (s_haddr !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h expected 0", s_haddr); end
        @(posedge hclk); #1;
        m_htrans = HTRANS_IDLE;
        hresetn  = 1'b1;
        @(posedge hclk); #1;
        $display("reset released");
    endtask

    task automatic test_read();
        int lowcnt, addrcyc, errcyc;
        logic [3:0] tor;
        logic wdb, hw, to;
        logic [31:0] rd;
        logic [1:0] rs;
        exp_t e;
        exp_q.push_back('{rdata: RD1, resp: HRESP_OKAY});
        do_xfer(32'h1000_0004, HTRANS_NONSEQ, 1'b0, 32'h0, 1, 0, 1'b0,
                lowcnt, addrcyc, errcyc, tor, wdb, hw, rd, rs, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL read_timeout: got timeout expected completion"); end
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL read_data: got %h expected %h", rd, e.rdata); end
        checks++; if (rs !== e.resp) begin errors++; $display("FAIL read_resp: got %b expected %b", rs, e.resp); end
        checks++; if (lowcnt != 1) begin errors++; $display("FAIL read_waits: got %0d expected 1", lowcnt); end
        checks++; if (tor !== 4'b1000 || addrcyc != 1) begin errors++; $display("FAIL read_htrans: got %b/%0d cycles expected 1000/1", tor, addrcyc); end
        checks++; if (hw !== 1'b0) begin errors++; $display("FAIL read_hwrite: got %b expected 0", hw); end
    endtask

    task automatic test_write_wait();
        int lowcnt, addrcyc, errcyc;
        logic [3:0] tor;
        logic wdb, hw, to;
        logic [31:0] rd;
        logic [1:0] rs;
        exp_t e;
        exp_q.push_back('{rdata: RD0, resp: HRESP_OKAY});
        do_xfer(32'h0000_0010, HTRANS_NONSEQ, 1'b1, 32'hA5A5_5A5A, 0, 3, 1'b0,
                lowcnt, addrcyc, errcyc, tor, wdb, hw, rd, rs, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL write_timeout: got timeout expected completion"); end
        checks++; if (lowcnt != 4) begin errors++; $display("FAIL write_waits: got %0d expected 4", lowcnt); end
        checks++; if (tor !== 4'b0010 || addrcyc != 1) begin errors++; $display("FAIL write_htrans: got %b/%0d cycles expected 0010/1", tor, addrcyc); end
        checks++; if (wdb !== 1'b0) begin errors++; $display("FAIL write_hwdata: got unstable expected stable A5A55A5A"); end
        checks++; if (hw !== 1'b1) begin errors++; $display("FAIL write_hwrite: got %b expected 1", hw); end
        checks++; if (rs !== e.resp) begin errors++; $display("FAIL write_resp: got %b expected %b", rs, e.resp); end
    endtask

    task automatic test_unmapped();
        int lowcnt, addrcyc, errcyc;
        logic [3:0] tor;
        logic wdb, hw, to;
        logic [31:0] rd;
        logic [1:0] rs;
        exp_t e;
        exp_q.push_back('{rdata: 32'h0, resp: HRESP_ERROR});
        do_xfer(32'h8000_0000, HTRANS_NONSEQ, 1'b0, 32'h0, 0, 0, 1'b0,
                lowcnt, addrcyc, errcyc, tor, wdb, hw, rd, rs, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL unmapped_timeout: got timeout expected completion"); end
        checks++; if (lowcnt != 1) begin errors++; $display("FAIL unmapped_waits: got %0d expected 1", lowcnt); end
        checks++; if (errcyc != 2) begin errors++; $display("FAIL unmapped_errcycles: got %0d expected 2", errcyc); end
        checks++; if (tor !== 4'b0000) begin errors++; $display("FAIL unmapped_htrans: got %b expected 0000", tor); end
        checks++; if (rs !== e.resp || rd !== e.rdata) begin errors++; $display("FAIL unmapped_resp: got %b/%h expected %b/%h", rs, rd, e.resp, e.rdata); end
    endtask

    task automatic test_slave_error();
        int lowcnt, addrcyc, errcyc;
        logic [3:0] tor;
        logic wdb, hw, to;
        logic [31:0] rd;
        logic [1:0] rs;
        exp_t e;
        exp_q.push_back('{rdata: RD0, resp: HRESP_ERROR});
        do_xfer(32'h0000_0020, HTRANS_NONSEQ, 1'b0, 32'h0, 0, 1, 1'b1,
                lowcnt, addrcyc, errcyc, tor, wdb, hw, rd, rs, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL slverr_timeout: got timeout expected completion"); end
        checks++; if (errcyc != 2) begin errors++; $display("FAIL slverr_errcycles: got %0d expected 2", errcyc); end
        checks++; if (lowcnt != 2) begin errors++; $display("FAIL slverr_waits: got %0d expected 2", lowcnt); end
        checks++; if (rs !== e.resp) begin errors++; $display("FAIL slverr_resp: got %b expected %b", rs, e.resp); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        m_haddr  = 32'h0000_0000;
        m_htrans = HTRANS_NONSEQ;
        m_hwrite = 1'b0;
        exp_q.push_back('{rdata: RD0, resp: HRESP_OKAY});
        exp_q.push_back('{rdata: RD1, resp: HRESP_OKAY});
        @(negedge hclk);
        checks++; if (m_hready !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", m_hready); end
        @(posedge hclk); #1;
        m_haddr  = 32'h1000_0000;
        m_htrans = HTRANS_SEQ;
        @(negedge hclk);
        checks++; if (s_htrans !== 4'b0010 || m_hready !== 1'b0) begin errors++; $display("FAIL b2b_addr0: got htrans %b hready %b expected 0010/0", s_htrans, m_hready); end
        checks++; if (s_hsize !== 3'b010 || s_hburst !== 3'b001 || s_hprot !== 4'b0011) begin errors++; $display("FAIL b2b_ctrl: got %b/%b/%b expected 010/001/0011", s_hsize, s_hburst, s_hprot); end
        @(posedge hclk); #1;
        @(negedge hclk);
        e = exp_q.pop_front();
        checks++; if (m_hready !== 1'b1 || m_hrdata !== e.rdata || m_hresp !== e.resp) begin errors++; $display("FAIL b2b_data0: got %b/%h/%b expected 1/%h/%b", m_hready, m_hrdata, m_hresp, e.rdata, e.resp); end
        checks++; if (s_htrans !== 4'b0000) begin errors++; $display("FAIL b2b_data0_htrans: got %b expected 0000", s_htrans); end
        $display("xfer addr=00000000 trans=2 wr=0 rdata=%h", m_hrdata);
        @(posedge hclk); #1;
        m_htrans = HTRANS_IDLE;
        @(negedge hclk);
        checks++; if (s_htrans !== 4'b1100 || s_haddr !== 32'h1000_0000) begin errors++; $display("FAIL b2b_addr1: got %b/%h expected 1100/10000000", s_htrans, s_haddr); end
        @(posedge hclk); #1;
        @(negedge hclk);
        e = exp_q.pop_front();
        checks++; if (m_hready !== 1'b1 || m_hrdata !== e.rdata || m_hresp !== e.resp) begin errors++; $display("FAIL b2b_data1: got %b/%h/%b expected 1/%h/%b", m_hready, m_hrdata, m_hresp, e.rdata, e.resp); end
        $display("xfer addr=10000000 trans=3 wr=0 rdata=%h", m_hrdata);
        @(posedge hclk); #1;
    endtask

    task automatic test_busy_idle();
        logic [1:0] tr;
        m_haddr = 32'h1000_0000;
        for (int i = 0; i < 4; i++) begin
            tr = (i < 2) ? HTRANS_BUSY : HTRANS_IDLE;
            m_htrans = tr;
            @(negedge hclk);
            checks++; if (m_hready !== 1'b1 || m_hresp !== HRESP_OKAY) begin errors++; $display("FAIL busyidle_resp: got %b/%b expected 1/00 (htrans %0d)", m_hready, m_hresp, tr); end
            checks++; if (s_htrans !== 4'b0000) begin errors++; $display("FAIL busyidle_htrans: got %b expected 0000 (htrans %0d)", s_htrans, tr); end
            $display("xfer addr=%h trans=%0d ignored hready=%b", m_haddr, tr, m_hready);
            @(posedge hclk); #1;
        end
        m_htrans = HTRANS_IDLE;
    endtask

    task automatic test_reset_mid();
        m_haddr  = 32'h1000_0008;
        m_htrans = HTRANS_NONSEQ;
        m_hwrite = 1'b0;
        @(posedge hclk); #1;
        m_htrans = HTRANS_IDLE;
        @(negedge hclk);
        checks++; if (s_htrans !== 4'b1000) begin errors++; $display("FAIL rstmid_addr: got %b expected 1000", s_htrans); end
        #2 hresetn = 1'b0;
        #1;
        checks++; if (m_hready !== 1'b1 || m_hresp !== HRESP_OKAY || m_hrdata !== 32'h0) begin errors++; $display("FAIL rstmid_master: got %b/%b/%h expected 1/00/0", m_hready, m_hresp, m_hrdata); end
        checks++; if (s_htrans !== 4'b0000 || s_haddr !== 32'h0) begin errors++; $display("FAIL rstmid_slave: got %b/%h expected 0000/0", s_htrans, s_haddr); end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        $display("reset pulsed during address phase");
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            checks++; if (s_htrans !== 4'b0000 || m_hready !== 1'b1) begin errors++; $display("FAIL rstmid_after: got %b/%b expected 0000/1", s_htrans, m_hready); end
            @(posedge hclk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_unmapped();
        test_back_to_back();
        test_busy_idle();
        test_slave_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
